lsu_ctrl: RTL and testbench

Parametrised load/store controller that replaces the core's single-cycle, combinational data-memory access with a ready/valid memory bus. It sits between the execute stage and data memory, accepts one access request at a time, and splits accesses that cross a bus-word boundary into two bus beats. It returns sign- or zero-extended load data, and holds `busy` high so the core stalls while an access is in flight.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_ctrl.sv | 136 +++++++++++++
 tb/tb_lsu_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: FSM state encoding,
// access-size encodings and the per-size byte mask.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE,
    ST_ERR
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      SZ_B:    byte_mask = 8'h01;
      SZ_H:    byte_mask = 8'h03;
      SZ_W:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte strobes and write data for both bus beats,
// split detection, and merge/extension of load data from the two beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int W     = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  beat0,
  input  logic [XLEN-1:0]  beat1,
  output logic             split,
  output logic [W-1:0]     strb0,
  output logic [W-1:0]     strb1,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1,
  output logic [XLEN-1:0]  rdata
);

  logic [2*W-1:0]    m2;
  logic [2*XLEN-1:0] d2;
  logic [XLEN-1:0]   raw;
  logic              sign_bit;
  int unsigned       n;

  // Shifting into a double-width vector yields beat 0 in the low half and the
  // spill-over (mask >> (W-off), data >> 8*(W-off)) in the high half.
  assign n      = 32'd1 << size;
  assign split  = (32'(off) + n) > 32'(W);
  assign m2     = (2*W)'(byte_mask(size)) << off;
  assign d2     = {{XLEN{1'b0}}, wdata} << (8 * off);
  assign strb0  = m2[W-1:0];
  assign strb1  = m2[2*W-1:W];
  assign wdata0 = d2[XLEN-1:0];
  assign wdata1 = d2[2*XLEN-1:XLEN];
  assign raw    = XLEN'({beat1, beat0} >> (8 * off));

  always_comb begin
    case (size)
      SZ_B:    sign_bit = raw[7];
      SZ_H:    sign_bit = raw[15];
      SZ_W:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
    rdata = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < n) rdata[8*i +: 8] = raw[8*i +: 8];
      else       rdata[8*i +: 8] = {8{sgn & sign_bit}};
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time over a ready/valid bus, with
// word-crossing accesses split into two beats and extended load results.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                busy,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_strb,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int W     = XLEN / 8;
  localparam int OFF_W = $clog2(W);

  lsu_state_e        state, state_nxt;
  logic              r_wr, r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr, base_addr, beat_addr;
  logic [XLEN-1:0]   r_wdata, r_rdata0, r_result;
  logic              accept, illegal, split;
  logic [W-1:0]      strb0, strb1;
  logic [XLEN-1:0]   wdata0, wdata1, ld_data, beat0_src;

  assign accept  = req_valid && req_ready;
  assign illegal = (XLEN == 32) && (req_size == SZ_D);

  // While beat 0 is returning, merge straight from the bus so a non-split
  // load can be captured in the same cycle.
  assign beat0_src = (state == ST_WAIT0) ? bus_rdata : r_rdata0;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off    (r_addr[OFF_W-1:0]),
    .size   (r_size),
    .sgn    (r_signed),
    .wdata  (r_wdata),
    .beat0  (beat0_src),
    .beat1  (bus_rdata),
    .split  (split),
    .strb0  (strb0),
    .strb1  (strb1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      r_wr     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_wr     <= req_wr;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (state == ST_WAIT0 && bus_rvalid) begin
        r_rdata0 <= bus_rdata;
        r_result <= ld_data;
      end
      if (state == ST_WAIT1 && bus_rvalid) r_result <= ld_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = illegal ? ST_ERR : ST_REQ0;
      end
      ST_REQ0: begin
        bus_valid = 1'b1;
        if (bus_ready) state_nxt = ST_WAIT0;
      end
      ST_WAIT0: if (bus_rvalid) state_nxt = split ? ST_REQ1 : ST_DONE;
      ST_REQ1: begin
        bus_valid = 1'b1;
        if (bus_ready) state_nxt = ST_WAIT1;
      end
      ST_WAIT1: if (bus_rvalid) state_nxt = ST_DONE;
      ST_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign base_addr  = r_addr & ~ADDR_W'(W - 1);
  assign beat_addr  = (state == ST_REQ1) ? base_addr + ADDR_W'(W) : base_addr;
  assign bus_addr   = bus_valid ? beat_addr : '0;
  assign bus_strb   = bus_valid ? ((state == ST_REQ1) ? strb1 : strb0) : '0;
  assign bus_wdata  = bus_valid ? ((state == ST_REQ1) ? wdata1 : wdata0) : '0;
  assign bus_wr     = bus_valid && r_wr;
  assign resp_rdata = (state == ST_DONE && !r_wr) ? r_result : '0;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: XLEN=64 instance for the main scenarios and an
// XLEN=32 instance for the illegal-size path.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;
  logic        bus_valid, bus_ready, bus_wr, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_strb;

  logic        d32_req_valid, d32_req_ready, d32_req_wr, d32_req_signed;
  logic [1:0]  d32_req_size;
  logic [31:0] d32_req_addr, d32_req_wdata;
  logic        d32_resp_valid, d32_resp_err, d32_busy;
  logic [31:0] d32_resp_rdata;
  logic        d32_bus_valid, d32_bus_ready, d32_bus_wr, d32_bus_rvalid;
  logic [31:0] d32_bus_addr, d32_bus_wdata, d32_bus_rdata;
  logic [3:0]  d32_bus_strb;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_strb(bus_strb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  lsu_ctrl #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(d32_req_valid), .req_ready(d32_req_ready), .req_wr(d32_req_wr),
    .req_size(d32_req_size), .req_signed(d32_req_signed), .req_addr(d32_req_addr),
    .req_wdata(d32_req_wdata), .resp_valid(d32_resp_valid), .resp_rdata(d32_resp_rdata),
    .resp_err(d32_resp_err), .busy(d32_busy), .bus_valid(d32_bus_valid),
    .bus_ready(d32_bus_ready), .bus_wr(d32_bus_wr), .bus_addr(d32_bus_addr),
    .bus_strb(d32_bus_strb), .bus_wdata(d32_bus_wdata), .bus_rvalid(d32_bus_rvalid),
    .bus_rdata(d32_bus_rdata)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a request for one cycle, then scrambles the request inputs so that
  // any use of unregistered fields shows up. Returns at the cycle-1 negedge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_wr = ~wr; req_size = ~sz; req_signed = ~sg;
    req_addr = ~a; req_wdata = ~wd;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if ({resp_valid, resp_err, busy, bus_valid, bus_wr} !== 5'b0) begin errors++; $display("FAIL reset_ctrl_outs: got %b want 00000", {resp_valid, resp_err, busy, bus_valid, bus_wr}); end
    checks++; if ({bus_addr, bus_wdata, resp_rdata, bus_strb} !== '0) begin errors++; $display("FAIL reset_data_outs: got %h want 0", {bus_addr, bus_wdata, resp_rdata, bus_strb}); end
    checks++; if (d32_req_ready !== 1'b1 || d32_bus_valid !== 1'b0) begin errors++; $display("FAIL reset_d32: got ready=%b valid=%b want 1/0", d32_req_ready, d32_bus_valid); end
  endtask

  task automatic test_aligned_load();
    issue(1'b0, 2'd3, 1'b0, 64'h1000, 64'h0);
    checks++; if ({bus_valid, bus_wr} !== 2'b10 || bus_addr !== 64'h1000 || bus_strb !== 8'hFF) begin errors++; $display("FAIL ld_beat0: got v=%b w=%b a=%h s=%h want 1 0 1000 ff", bus_valid, bus_wr, bus_addr, bus_strb); end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    checks++; if (bus_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ld_wait0: got v=%b rv=%b busy=%b want 0 0 1", bus_valid, resp_valid, busy); end
    bus_rvalid = 1'b1; bus_rdata = 64'h1122334455667788;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'h1122334455667788) begin errors++; $display("FAIL ld_resp: got rv=%b err=%b d=%h want 1 0 1122334455667788", resp_valid, resp_err, resp_rdata); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ld_idle: got rv=%b rdy=%b busy=%b want 0 1 0", resp_valid, req_ready, busy); end
  endtask

  task automatic test_split_lh();
    issue(1'b0, 2'd1, 1'b1, 64'h1007, 64'h0);
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1000 || bus_strb !== 8'h80) begin errors++; $display("FAIL lh_beat0: got v=%b a=%h s=%h want 1 1000 80", bus_valid, bus_addr, bus_strb); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'hAB11223344556677; step();
    bus_rvalid = 1'b0;
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h1008 || bus_strb !== 8'h01 || resp_valid !== 1'b0) begin errors++; $display("FAIL lh_beat1: got v=%b a=%h s=%h rv=%b want 1 1008 01 0", bus_valid, bus_addr, bus_strb, resp_valid); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h99887766554433CD; step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFFFFFFFFFFCDAB) begin errors++; $display("FAIL lh_resp: got rv=%b d=%h want 1 ffffffffffffcdab", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_split_sw();
    issue(1'b1, 2'd2, 1'b0, 64'h2006, 64'h00000000DEADBEEF);
    checks++; if ({bus_valid, bus_wr} !== 2'b11 || bus_addr !== 64'h2000 || bus_strb !== 8'hC0 || bus_wdata !== 64'hBEEF000000000000) begin errors++; $display("FAIL sw_beat0: got w=%b a=%h s=%h d=%h want 1 2000 c0 beef000000000000", bus_wr, bus_addr, bus_strb, bus_wdata); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h5555555555555555; step();
    bus_rvalid = 1'b0;
    checks++; if ({bus_valid, bus_wr} !== 2'b11 || bus_addr !== 64'h2008 || bus_strb !== 8'h03 || bus_wdata !== 64'h000000000000DEAD) begin errors++; $display("FAIL sw_beat1: got w=%b a=%h s=%h d=%h want 1 2008 03 dead", bus_wr, bus_addr, bus_strb, bus_wdata); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin errors++; $display("FAIL sw_resp: got rv=%b d=%h want 1 0", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue(1'b1, 2'd2, 1'b0, 64'h3004, 64'h00000000CAFEF00D);
    for (int c = 1; c <= 6; c++) begin
      if (bus_valid !== 1'b1 || bus_wr !== 1'b1 || busy !== 1'b1 || bus_addr !== 64'h3000 ||
          bus_strb !== 8'hF0 || bus_wdata !== 64'hCAFEF00D00000000 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got v=%b a=%h s=%h d=%h busy=%b", c, bus_valid, bus_addr, bus_strb, bus_wdata, busy);
      end
      if (c == 6) bus_ready = 1'b1;
      step();
    end
    bus_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0", bad); end
    checks++; if (bus_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_wait0: got v=%b rv=%b busy=%b want 0 0 1", bus_valid, resp_valid, busy); end
    bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_cycle8: got rv=%b want 1", resp_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'd3, 1'b0, 64'h40, 64'h0);
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h0123456789ABCDEF; step();
    bus_rvalid = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b1; req_addr = 64'h45; req_wdata = '0;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_done: got rv=%b rdy=%b want 1 0", resp_valid, req_ready); end
    step();
    checks++; if (req_ready !== 1'b1 || bus_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got rdy=%b v=%b want 1 0", req_ready, bus_valid); end
    step();
    req_valid = 1'b0; req_addr = 64'hFFF0; req_size = 2'd3; req_signed = 1'b0;
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h40 || bus_strb !== 8'h20) begin errors++; $display("FAIL b2b_beat0: got v=%b a=%h s=%h want 1 40 20", bus_valid, bus_addr, bus_strb); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h1111_8022_3344_5566; step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFFFFFFFFFFFF80) begin errors++; $display("FAIL lb_resp: got rv=%b d=%h want 1 ffffffffffffff80", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_wrap();
    issue(1'b0, 2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    checks++; if (bus_addr !== 64'hFFFFFFFFFFFFFFF8 || bus_strb !== 8'h80) begin errors++; $display("FAIL wrap_beat0: got a=%h s=%h want fffffffffffffff8 80", bus_addr, bus_strb); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h8000000000000000; step();
    bus_rvalid = 1'b0;
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 64'h0 || bus_strb !== 8'h01) begin errors++; $display("FAIL wrap_beat1: got v=%b a=%h s=%h want 1 0 01", bus_valid, bus_addr, bus_strb); end
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h00000000000000F1; step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h000000000000F180) begin errors++; $display("FAIL lhu_resp: got rv=%b d=%h want 1 f180", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_illegal_size();
    d32_req_valid = 1'b1; d32_req_size = 2'd3; d32_req_addr = 32'h100; d32_req_wr = 1'b0;
    step();
    d32_req_valid = 1'b0; d32_req_size = 2'd0;
    checks++; if (d32_resp_valid !== 1'b1 || d32_resp_err !== 1'b1 || d32_resp_rdata !== 32'h0 || d32_bus_valid !== 1'b0) begin errors++; $display("FAIL ill_resp: got rv=%b err=%b d=%h bv=%b want 1 1 0 0", d32_resp_valid, d32_resp_err, d32_resp_rdata, d32_bus_valid); end
    step();
    checks++; if (d32_resp_valid !== 1'b0 || d32_resp_err !== 1'b0 || d32_req_ready !== 1'b1 || d32_bus_valid !== 1'b0) begin errors++; $display("FAIL ill_after: got rv=%b err=%b rdy=%b bv=%b want 0 0 1 0", d32_resp_valid, d32_resp_err, d32_req_ready, d32_bus_valid); end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 2'd1, 1'b1, 64'h1007, 64'h0);
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'hAB00000000000000; step();
    bus_rvalid = 1'b0;
    bus_ready = 1'b1; step(); bus_ready = 1'b0;
    checks++; if (busy !== 1'b1 || bus_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rma_in_wait1: got busy=%b v=%b rdy=%b want 1 0 0", busy, bus_valid, req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || bus_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rma_async: got rdy=%b v=%b busy=%b want 1 0 0", req_ready, bus_valid, busy); end
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h00000000000000CD;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rma_late_rvalid: got rv=%b busy=%b rdy=%b want 0 0 1", resp_valid, busy, req_ready); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rma_no_resp: got rv=%b want 0", resp_valid); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_size = '0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    d32_req_valid = 1'b0; d32_req_wr = 1'b0; d32_req_size = '0; d32_req_signed = 1'b0;
    d32_req_addr = '0; d32_req_wdata = '0;
    d32_bus_ready = 1'b0; d32_bus_rvalid = 1'b0; d32_bus_rdata = '0;
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_aligned_load();
    test_split_lh();
    test_split_sw();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_illegal_size();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
